// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: opcode patterns, exception causes,
// the registered control bundle and the exception FSM state type.
package legv8_pkg;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100???;
    localparam logic [10:0] OP_CBNZ = 11'b10110101???;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ADDI = 11'b1001000100?;
    localparam logic [10:0] OP_SUBI = 11'b1101000100?;
    localparam logic [10:0] OP_ERET = 11'b11010110100;
    localparam logic [10:0] OP_MRS  = 11'b11010101001;

    localparam logic [3:0] ESR_ILLEGAL  = 4'h1;
    localparam logic [3:0] ESR_IRQ_BASE = 4'h8;
    localparam logic [3:0] ESR_DFAULT   = 4'hF;

    typedef struct packed {
        logic       Reg2Loc;
        logic [1:0] ALUSrc;
        logic       MemtoReg;
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic       Branch;
        logic [1:0] ALUOp;
        logic       ERet;
        logic       NotAnInstr;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef enum logic [1:0] {
        EXC_RUN     = 2'd0,
        EXC_HANDLER = 2'd1,
        EXC_FAULT   = 2'd2
    } exc_state_t;

endpackage

// File: rtl/maindec_core.sv
// Combinational opcode-to-control decoder with a legality flag; ADDI/SUBI
// decode only when HAS_IMM is set.
module maindec_core
    import legv8_pkg::*;
#(
    parameter int OP_W    = 11,
    parameter bit HAS_IMM = 1'b1
) (
    input  logic [OP_W-1:0] Op,
    output ctrl_t           o_ctrl,
    output logic            o_legal,
    output logic            o_isEret
);

    always_comb begin
        o_ctrl   = CTRL_NOP;
        o_legal  = 1'b1;
        o_isEret = 1'b0;
        casez (Op)
            OP_LDUR: begin
                o_ctrl.ALUSrc   = 2'b01;
                o_ctrl.MemtoReg = 1'b1;
                o_ctrl.RegWrite = 1'b1;
                o_ctrl.MemRead  = 1'b1;
            end
            OP_STUR: begin
                o_ctrl.Reg2Loc  = 1'b1;
                o_ctrl.ALUSrc   = 2'b01;
                o_ctrl.MemWrite = 1'b1;
            end
            OP_CBZ, OP_CBNZ: begin
                o_ctrl.Reg2Loc = 1'b1;
                o_ctrl.Branch  = 1'b1;
                o_ctrl.ALUOp   = 2'b01;
            end
            OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                o_ctrl.RegWrite = 1'b1;
                o_ctrl.ALUOp    = 2'b10;
            end
            OP_ADDI, OP_SUBI: begin
                if (HAS_IMM) begin
                    o_ctrl.ALUSrc   = 2'b01;
                    o_ctrl.RegWrite = 1'b1;
                    o_ctrl.ALUOp    = 2'b10;
                end else begin
                    o_legal = 1'b0;
                end
            end
            OP_ERET: begin
                o_ctrl.Branch = 1'b1;
                o_ctrl.ALUOp  = 2'b01;
                o_ctrl.ERet   = 1'b1;
                o_isEret      = 1'b1;
            end
            OP_MRS: begin
                o_ctrl.Reg2Loc  = 1'b1;
                o_ctrl.ALUSrc   = 2'b10;
                o_ctrl.RegWrite = 1'b1;
                o_ctrl.ALUOp    = 2'b01;
            end
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/maindec_seq.sv
// Registered, exception-aware LEGv8 main decoder: one-cycle decode latency,
// stall hold, and a RUN/HANDLER/FAULT exception machine feeding the exception unit.
module maindec_seq
    import legv8_pkg::*;
#(
    parameter int OP_W    = 11,
    parameter int NUM_IRQ = 4,
    parameter bit HAS_IMM = 1'b1,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    Op,
    input  logic               instr_valid,
    input  logic               stall,
    input  logic [NUM_IRQ-1:0] irq,
    output logic               Reg2Loc,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               Branch,
    output logic               ERet,
    output logic               NotAnInstr,
    output logic [1:0]         ALUOp,
    output logic [1:0]         ALUSrc,
    output logic               Exc,
    output logic [3:0]         ESR,
    output logic               in_handler,
    output logic               fault,
    output logic [CNT_W-1:0]   exc_count
);

    if (OP_W != 11) begin : g_badOpW
        $error("maindec_seq: OP_W must be 11");
    end
    if (NUM_IRQ < 1 || NUM_IRQ > 8) begin : g_badNumIrq
        $error("maindec_seq: NUM_IRQ must be 1..8");
    end

    exc_state_t       r_state;
    exc_state_t       w_stateNext;
    ctrl_t            r_ctrl;
    ctrl_t            w_ctrlNext;
    ctrl_t            w_dec;
    logic             w_legal;
    logic             w_isEret;
    logic             r_exc;
    logic             w_excNext;
    logic [3:0]       r_esr;
    logic [3:0]       w_esrNext;
    logic             r_fault;
    logic             w_faultNext;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       w_irqIdx;
    logic             w_irqAny;

    maindec_core #(
        .OP_W    (OP_W),
        .HAS_IMM (HAS_IMM)
    ) u_core (
        .Op       (Op),
        .o_ctrl   (w_dec),
        .o_legal  (w_legal),
        .o_isEret (w_isEret)
    );

    // Scan downward so the lowest asserted line wins.
    always_comb begin
        w_irqIdx = 3'd0;
        w_irqAny = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq[i]) begin
                w_irqIdx = 3'(i);
                w_irqAny = 1'b1;
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_ctrlNext  = CTRL_NOP;
        w_excNext   = 1'b0;
        w_esrNext   = r_esr;
        w_faultNext = r_fault;
        case (r_state)
            EXC_RUN: begin
                if (instr_valid) begin
                    if (!w_legal || w_isEret) begin
                        w_ctrlNext.NotAnInstr = 1'b1;
                        w_excNext   = 1'b1;
                        w_esrNext   = ESR_ILLEGAL;
                        w_stateNext = EXC_HANDLER;
                    end else if (w_irqAny) begin
                        w_excNext   = 1'b1;
                        w_esrNext   = ESR_IRQ_BASE | {1'b0, w_irqIdx};
                        w_stateNext = EXC_HANDLER;
                    end else begin
                        w_ctrlNext = w_dec;
                    end
                end
            end
            EXC_HANDLER: begin
                // The slot right after entry is the faulting instruction's shadow;
                // squashing it also keeps Exc from firing on back-to-back cycles.
                if (instr_valid && !r_exc) begin
                    if (w_isEret) begin
                        w_ctrlNext  = w_dec;
                        w_stateNext = EXC_RUN;
                    end else if (!w_legal) begin
                        w_ctrlNext.NotAnInstr = 1'b1;
                        w_excNext   = 1'b1;
                        w_esrNext   = ESR_DFAULT;
                        w_faultNext = 1'b1;
                        w_stateNext = EXC_FAULT;
                    end else begin
                        w_ctrlNext = w_dec;
                    end
                end
            end
            EXC_FAULT: w_stateNext = EXC_FAULT;
            default:   w_stateNext = EXC_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EXC_RUN;
            r_ctrl  <= CTRL_NOP;
            r_exc   <= 1'b0;
            r_esr   <= '0;
            r_fault <= 1'b0;
            r_count <= '0;
        end else if (stall) begin
            r_exc <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_ctrl  <= w_ctrlNext;
            r_exc   <= w_excNext;
            r_esr   <= w_esrNext;
            r_fault <= w_faultNext;
            if (w_excNext && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign Reg2Loc    = r_ctrl.Reg2Loc;
    assign ALUSrc     = r_ctrl.ALUSrc;
    assign MemtoReg   = r_ctrl.MemtoReg;
    assign RegWrite   = r_ctrl.RegWrite;
    assign MemRead    = r_ctrl.MemRead;
    assign MemWrite   = r_ctrl.MemWrite;
    assign Branch     = r_ctrl.Branch;
    assign ALUOp      = r_ctrl.ALUOp;
    assign ERet       = r_ctrl.ERet;
    assign NotAnInstr = r_ctrl.NotAnInstr;
    assign Exc        = r_exc;
    assign ESR        = r_esr;
    assign in_handler = (r_state == EXC_HANDLER);
    assign fault      = r_fault;
    assign exc_count  = r_count;

endmodule
